// File: rtl/ahmes_pkg.sv
// rtl/ahmes_pkg.sv - Ahmes opcodes, fetch states and instruction classification
package ahmes_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_STA = 8'h10;
    localparam logic [7:0] OP_LDA = 8'h20;
    localparam logic [7:0] OP_ADD = 8'h30;
    localparam logic [7:0] OP_OR  = 8'h40;
    localparam logic [7:0] OP_AND = 8'h50;
    localparam logic [7:0] OP_NOT = 8'h60;
    localparam logic [7:0] OP_SUB = 8'h70;
    localparam logic [7:0] OP_JMP = 8'h80;
    localparam logic [7:0] OP_JN  = 8'h90;
    localparam logic [7:0] OP_JP  = 8'h94;
    localparam logic [7:0] OP_JV  = 8'h98;
    localparam logic [7:0] OP_JNV = 8'h9C;
    localparam logic [7:0] OP_JZ  = 8'hA0;
    localparam logic [7:0] OP_JNZ = 8'hA4;
    localparam logic [7:0] OP_JC  = 8'hB0;
    localparam logic [7:0] OP_JNC = 8'hB4;
    localparam logic [7:0] OP_JB  = 8'hB8;
    localparam logic [7:0] OP_JNB = 8'hBC;
    localparam logic [7:0] OP_SHR = 8'hE0;
    localparam logic [7:0] OP_SHL = 8'hE1;
    localparam logic [7:0] OP_ROR = 8'hE2;
    localparam logic [7:0] OP_ROL = 8'hE3;
    localparam logic [7:0] OP_HLT = 8'hF0;

    typedef enum logic [2:0] {
        START, FETCH_OP, INC_OP, FETCH_ARG, BRANCH, ISSUE, HALT
    } fetch_state_t;

    typedef enum logic [2:0] {
        ONE_BYTE, TWO_BYTE, JUMP, HALT_I, ILLEGAL
    } instr_class_t;

    function automatic instr_class_t classify(input logic [7:0] op);
        instr_class_t cls;
        case (op[7:4])
            OP_NOP[7:4], OP_NOT[7:4]: cls = ONE_BYTE;
            OP_STA[7:4], OP_LDA[7:4], OP_ADD[7:4],
            OP_OR[7:4], OP_AND[7:4], OP_SUB[7:4]: cls = TWO_BYTE;
            OP_JMP[7:4], OP_JN[7:4], OP_JZ[7:4], OP_JC[7:4]: cls = JUMP;
            default: cls = ILLEGAL;
        endcase
        // Full-byte exceptions inside the otherwise undefined 0xEx/0xFx rows
        case (op)
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = ONE_BYTE;
            OP_HLT: cls = HALT_I;
            default: ;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ahmes_branch_cond.sv
// rtl/ahmes_branch_cond.sv - jump condition evaluation from opcode and ALU flags
module ahmes_branch_cond
    import ahmes_pkg::*;
(
    input  logic [7:0] ir,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    input  logic       flag_b,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        if (ir[7:4] == OP_JMP[7:4]) begin
            taken = 1'b1;
        end else begin
            case ({ir[7:2], 2'b00})
                OP_JN:   taken = flag_n;
                OP_JP:   taken = !flag_n && !flag_z;
                OP_JV:   taken = flag_v;
                OP_JNV:  taken = !flag_v;
                OP_JZ:   taken = flag_z;
                OP_JNZ:  taken = !flag_z;
                OP_JC:   taken = flag_c;
                OP_JNC:  taken = !flag_c;
                OP_JB:   taken = flag_b;
                OP_JNB:  taken = !flag_b;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ahmes_fetch_unit.sv
// rtl/ahmes_fetch_unit.sv - Ahmes instruction fetch and branch sequencer driving the PC
module ahmes_fetch_unit
    import ahmes_pkg::*;
#(
    parameter int ACK_TIMEOUT    = 15,
    parameter bit ILLEGAL_AS_NOP = 1'b1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [7:0] pc_in,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    input  logic       flag_b,
    output logic [7:0] ir,
    output logic [7:0] operand,
    output logic       instr_valid,
    input  logic       exec_done,
    output logic       illegal,
    output logic       bus_err,
    output logic       halted
);

    fetch_state_t r_state, w_next;
    logic [7:0]   r_ir, r_operand;
    logic [15:0]  r_to_cnt;
    logic         r_bus_err;
    logic         w_taken, w_in_fetch, w_timeout;
    instr_class_t w_class;

    ahmes_branch_cond u_cond (
        .ir     (r_ir),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .flag_b (flag_b),
        .taken  (w_taken)
    );

    assign w_class    = classify(r_ir);
    assign w_in_fetch = (r_state == FETCH_OP) || (r_state == FETCH_ARG);
    // Fires on the ACK_TIMEOUT-th consecutive unacknowledged request cycle
    assign w_timeout  = (ACK_TIMEOUT != 0) && w_in_fetch && !mem_ack &&
                        (r_to_cnt == 16'(ACK_TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (r_state)
            START: w_next = FETCH_OP;
            FETCH_OP, FETCH_ARG: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next = (r_state == FETCH_OP) ? INC_OP : BRANCH;
                end else if (w_timeout) begin
                    w_next = HALT;
                end
            end
            INC_OP: begin
                pc_inc = 1'b1;
                case (w_class)
                    ONE_BYTE:       w_next = ISSUE;
                    TWO_BYTE, JUMP: w_next = FETCH_ARG;
                    HALT_I:         w_next = HALT;
                    default: begin
                        illegal = 1'b1;
                        w_next  = ILLEGAL_AS_NOP ? ISSUE : HALT;
                    end
                endcase
            end
            BRANCH: begin
                if (w_class == JUMP && w_taken) begin
                    pc_load = 1'b1;
                    w_next  = FETCH_OP;
                end else begin
                    pc_inc = 1'b1;
                    w_next = (w_class == JUMP) ? FETCH_OP : ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    w_next = FETCH_OP;
                end
            end
            HALT:    halted = 1'b1;
            default: w_next = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= START;
            r_ir      <= 8'h00;
            r_operand <= 8'h00;
            r_to_cnt  <= 16'h0000;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH_OP && mem_ack) begin
                r_ir <= mem_rdata;
            end
            if (r_state == FETCH_ARG && mem_ack) begin
                r_operand <= mem_rdata;
            end
            if (!w_in_fetch || mem_ack) begin
                r_to_cnt <= 16'h0000;
            end else begin
                r_to_cnt <= r_to_cnt + 16'h0001;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign mem_addr = mem_req ? pc_out : 8'h00;
    assign pc_in    = r_operand;
    assign ir       = r_ir;
    assign operand  = r_operand;
    assign bus_err  = r_bus_err;

endmodule

// File: doc/ahmes_fetch_unit.md
Name: ahmes_fetch_unit

Overview:
- Instruction fetch/branch sequencer for the Ahmes CPU, and the controlling end of the PC interface: it generates pc_inc, pc_load and pc_in, and it reads pc_out.
- Fetches the opcode and optional operand byte from memory over a req/ack handshake.
- Resolves all jumps locally against the ALU flags and hands every non-jump instruction to the execute stage with a valid/done handshake.

Parameters:
- ACK_TIMEOUT, 15: maximum cycles mem_req may stay high without mem_ack before bus error; 0 disables the check.
- ILLEGAL_AS_NOP, 1: 1 executes undefined opcodes as one-byte NOP with an illegal pulse; 0 halts on them.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; one clock; asynchronous assert, active-low.
- pc_out  in  8  current PC value.
- pc_inc  out  1  one-cycle increment request to the PC.
- pc_load  out  1  one-cycle load request to the PC; has priority over pc_inc and is never asserted together with it.
- pc_in  out  8  load value; equals the operand register.
- mem_req  out  1  memory read request.
- mem_addr  out  8  read address; equals pc_out while mem_req=1.
- mem_rdata  in  8  read data; valid in the mem_ack cycle.
- mem_ack  in  1  read complete.
- flag_n, flag_z, flag_c, flag_v, flag_b  in  1 each  ALU flags.
- ir  out  8  latched opcode.
- operand  out  8  latched operand byte.
- instr_valid  out  1  instruction in ir/operand is ready for execute.
- exec_done  in  1  execute has finished the issued instruction.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  sticky; set on ack timeout.
- halted  out  1  high in HALT.

Behaviour:
- Reset: state START. ir, operand and the timeout counter are 0. Every output is 0.
- Outputs are decoded from state (Moore). ir and operand update only on an accepted mem_ack.
- START: lasts 1 cycle, then FETCH_OP.
- FETCH_OP:
  - mem_req=1, mem_addr=pc_out.
  - On mem_ack: ir<=mem_rdata, go to INC_OP.
- INC_OP:
  - pc_inc=1 for exactly 1 cycle; decode ir.
  - Opcode 0xF0 (HLT): go to HALT.
  - One-byte instructions (NOP 0x0x, NOT 0x6x, SHR/SHL/ROR/ROL 0xE0-0xE3): go to ISSUE.
  - Two-byte instructions (STA/LDA/ADD/OR/AND/SUB 0x1x-0x5x, 0x7x; JMP 0x8x; conditional jumps 0x9x/0xAx/0xBx): go to FETCH_ARG.
  - Undefined opcodes (0xCx, 0xDx, 0xE4-0xEF, 0xF1-0xFF): illegal=1. With ILLEGAL_AS_NOP=1 go to ISSUE as NOP; with 0 go to HALT.
- FETCH_ARG:
  - mem_req=1, mem_addr=pc_out (already incremented).
  - On mem_ack: operand<=mem_rdata, go to BRANCH.
- BRANCH (1 cycle):
  - Jump taken: pc_load=1, then FETCH_OP.
  - Jump not taken: pc_inc=1, then FETCH_OP.
  - Non-jump: pc_inc=1, then ISSUE.
  - Flags are sampled in this cycle only.
- Jump conditions are selected by ir[7:4] and ir[3:2]:
  - 0x80 JMP: always.
  - 0x90 JN: N=1. 0x94 JP: N=0 and Z=0. 0x98 JV: V=1. 0x9C JNV: V=0.
  - 0xA0 JZ: Z=1. 0xA4 JNZ: Z=0.
  - 0xB0 JC: C=1. 0xB4 JNC: C=0. 0xB8 JB: B=1. 0xBC JNB: B=0.
  - Low bits ir[1:0] are ignored.
- ISSUE:
  - instr_valid=1 until exec_done. On exec_done, go to FETCH_OP next cycle.
  - exec_done outside ISSUE is ignored.
  - The memory bus belongs to execute while in ISSUE (STA/LDA); mem_req=0.
- HALT: halted=1, all other requests 0; left only by reset.
- Timeout:
  - The counter clears on entry to each FETCH state and counts while mem_req=1 and mem_ack=0.
  - Reaching ACK_TIMEOUT sets bus_err and goes to HALT.
- Address wrap: PC 0xFF increments to 0x00 (handled by the PC); fetch at 0xFF then 0x00 is legal.
- Reset mid-transaction: immediate return to START. A pending mem_ack after reset is ignored.
- Minimum cycles with zero-wait memory (mem_ack in the request cycle):
  - One-byte instruction: 3 + exec.
  - Two-byte instruction: 5 + exec.
  - Jump: 4.

Decomposition:
- Package ahmes_pkg holds:
  - Opcode constants (OP_NOP..OP_HLT, jump sub-codes).
  - The fetch_state_t enum {START, FETCH_OP, INC_OP, FETCH_ARG, BRANCH, ISSUE, HALT}.
  - An instr_class_t enum {ONE_BYTE, TWO_BYTE, JUMP, HALT_I, ILLEGAL}.
- Sub-module ahmes_branch_cond: combinational; inputs ir and the five flags, output taken.

Test Plan:
- Reset, then memory holds [0x20,0x80] (LDA 80h), zero-wait -> mem_addr 0x00 then 0x01; pc_inc pulses twice; instr_valid with ir=0x20, operand=0x80; after exec_done, next fetch at 0x02.
- JZ 0x10 at 0x05 with Z=1 -> pc_load=1, pc_in=0x10, no instr_valid. Same with Z=0 -> pc_inc and next fetch at 0x07.
- JP with N=0, Z=1 -> not taken. With N=0, Z=0 -> taken. JNB with B=0 -> taken.
- NOT (0x60), then HLT (0xF0) -> one fetch for NOT, instr_valid; HLT gives halted=1 and no further mem_req; exec_done is ignored.
- mem_ack withheld 15 cycles with ACK_TIMEOUT=15 -> bus_err=1, halted=1. An ack after 3 wait cycles -> normal completion.
- Opcode 0xC5 with ILLEGAL_AS_NOP=1 -> illegal pulse, treated as NOP. reset_n low during FETCH_ARG -> all outputs 0 at once; restart via START.
